// File: rtl/phase_gen.sv
// Multi-channel phase-strobe generator: a programmable-period tick counter drives
// NUM_CH registered [rise, fall) windows, with shadow config committed at period boundaries.
module phase_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 6,
  parameter int PERIOD_INIT = 20,
  parameter logic [NUM_CH*CNT_W-1:0] RISE_INIT = {6'd19, 6'd1, 6'd7, 6'd0},
  parameter logic [NUM_CH*CNT_W-1:0] FALL_INIT = {6'd20, 6'd2, 6'd14, 6'd0}
) (
  input  logic                         clk_100M,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         oneshot,
  input  logic                         run_en,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_CH+1)-1:0]  cfg_sel,
  input  logic [CNT_W-1:0]             cfg_rise,
  input  logic [CNT_W-1:0]             cfg_fall,
  output logic [NUM_CH-1:0]            ph_out,
  output logic [CNT_W-1:0]             cnt,
  output logic                         period_start,
  output logic                         period_done,
  output logic                         busy,
  output logic                         cfg_pending
);

  localparam int SEL_W = $clog2(NUM_CH+1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ph_q, ph_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                pending_q;

  logic [CNT_W-1:0]    actRise_q [NUM_CH];
  logic [CNT_W-1:0]    actFall_q [NUM_CH];
  logic [CNT_W-1:0]    shRise_q  [NUM_CH];
  logic [CNT_W-1:0]    shFall_q  [NUM_CH];
  logic [CNT_W-1:0]    actPer_q, shPer_q;

  logic                wrap, commit, cfgHit;
  logic [CNT_W-1:0]    perWr;

  assign wrap   = (state_q == RUN) && run_en && (cnt_q == actPer_q - CNT_W'(1));
  assign commit = (state_q == IDLE) || wrap;
  assign cfgHit = cfg_we && (cfg_sel <= SEL_W'(NUM_CH));
  assign perWr  = (cfg_rise < CNT_W'(2)) ? CNT_W'(2) : cfg_rise;

  // Status pulses are registered alongside ph_out, so they lag the tick they describe by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        ph_d  = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (run_en) begin
          start_d = (cnt_q == '0);
          done_d  = wrap;
          cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            ph_d[i] = (cnt_q >= actRise_q[i]) && (cnt_q < actFall_q[i]);
          end
          if (wrap && oneshot) begin
            state_d = IDLE;
            ph_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // A write coinciding with a commit lands in shadow after the copy, so it stays pending.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        actRise_q[i] <= RISE_INIT[i*CNT_W +: CNT_W];
        actFall_q[i] <= FALL_INIT[i*CNT_W +: CNT_W];
        shRise_q[i]  <= RISE_INIT[i*CNT_W +: CNT_W];
        shFall_q[i]  <= FALL_INIT[i*CNT_W +: CNT_W];
      end
      actPer_q  <= CNT_W'(PERIOD_INIT);
      shPer_q   <= CNT_W'(PERIOD_INIT);
      pending_q <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          actRise_q[i] <= shRise_q[i];
          actFall_q[i] <= shFall_q[i];
        end
        actPer_q <= shPer_q;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfgHit && (cfg_sel == SEL_W'(i))) begin
          shRise_q[i] <= cfg_rise;
          shFall_q[i] <= cfg_fall;
        end
      end
      if (cfgHit && (cfg_sel == SEL_W'(NUM_CH))) shPer_q <= perWr;
      pending_q <= cfgHit | (pending_q & ~commit);
    end
  end

  assign ph_out       = ph_q;
  assign cnt          = cnt_q;
  assign period_start = start_q;
  assign period_done  = done_q;
  assign busy         = (state_q == RUN);
  assign cfg_pending  = pending_q;

endmodule
